// File: rtl/accum_cpu.sv
// Accumulator processor with a configurable word/address width, a ready-handshake bus
// to one shared instruction/data memory, flags {C,Z}, immediate loads, conditional jumps and halt.
module accum_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready,
  output logic              req,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              halted,
  output logic [1:0]        flags
);

  typedef enum logic [2:0] {FETCH, DECODE, OPND, MEM, HALT} state_t;

  localparam logic [7:0] OP_LDA = 8'h01, OP_STA = 8'h02, OP_GPC = 8'h03, OP_SPC = 8'h04,
                         OP_MAB = 8'h05, OP_MBA = 8'h06, OP_LDI = 8'h07, OP_JMP = 8'h08,
                         OP_JZ  = 8'h09, OP_JC  = 8'h0A, OP_HLT = 8'h0F,
                         OP_ADD = 8'h10, OP_SUB = 8'h11, OP_MUL = 8'h12, OP_DIV = 8'h13,
                         OP_AND = 8'h14, OP_OR  = 8'h15, OP_XOR = 8'h16, OP_NOT = 8'h17;

  state_t              state;
  logic [DATA_W-1:0]   a, b;
  logic [ADDR_W-1:0]   pc;
  logic [7:0]          inst;   // only the opcode byte is ever decoded
  logic [ADDR_W-1:0]   opr;    // only the address bits of an operand outlive OPND
  logic                z, c;

  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                is_alu;
  logic [DATA_W-1:0]   pc_ext;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign prod   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign is_alu = (inst[7:3] == 5'b00010);
  assign pc_ext = DATA_W'(pc);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    alu_res = a;
    alu_c   = 1'b0;
    case (inst)
      OP_ADD: {alu_c, alu_res} = sum;
      OP_SUB: begin
        alu_res = a - b;
        alu_c   = (a < b);
      end
      OP_MUL: begin
        alu_res = prod[DATA_W-1:0];
        alu_c   = |prod[2*DATA_W-1:DATA_W];
      end
      OP_DIV: begin
        if (b == '0) begin
          alu_res = '1;
          alu_c   = 1'b1;
        end else begin
          alu_res = a / b;
        end
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      default: ;
    endcase
  end

  // Reset gates req directly so nothing is requested while rst is held.
  assign req      = !rst && (state == FETCH || state == OPND || state == MEM);
  assign we       = req && (state == MEM) && (inst == OP_STA);
  assign addr     = !req ? '0 : (state == MEM) ? opr : pc;
  assign data_out = we ? a : '0;
  assign halted   = (state == HALT);
  assign flags    = {c, z};

  // NOTE: all state below is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      a     <= '0;
      b     <= '0;
      inst  <= '0;
      opr   <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (ready) begin
            inst  <= data_in[7:0];
            pc    <= pc + 1'b1;
            state <= DECODE;
          end
        end

        DECODE: begin
          state <= FETCH;
          if (is_alu) begin
            a <= alu_res;
            z <= (alu_res == '0);
            c <= alu_c;
          end else begin
            case (inst)
              OP_LDA, OP_STA, OP_LDI, OP_JMP, OP_JZ, OP_JC: state <= OPND;
              OP_HLT: state <= HALT;
              OP_GPC: begin
                a <= pc_ext;
                z <= (pc_ext == '0);
              end
              OP_SPC: pc <= a[ADDR_W-1:0];
              OP_MAB: begin
                a <= b;
                z <= (b == '0);
              end
              OP_MBA: b <= a;
              default: ;
            endcase
          end
        end

        OPND: begin
          if (ready) begin
            opr   <= data_in[ADDR_W-1:0];
            pc    <= pc + 1'b1;
            state <= FETCH;
            case (inst)
              OP_LDA, OP_STA: state <= MEM;
              OP_LDI: begin
                a <= data_in;
                z <= (data_in == '0);
              end
              OP_JMP: pc <= data_in[ADDR_W-1:0];
              OP_JZ:  if (z) pc <= data_in[ADDR_W-1:0];
              OP_JC:  if (c) pc <= data_in[ADDR_W-1:0];
              default: ;
            endcase
          end
        end

        MEM: begin
          if (ready) begin
            if (inst == OP_LDA) begin
              a <= data_in;
              z <= (data_in == '0);
            end
            state <= FETCH;
          end
        end

        HALT: state <= HALT;

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_cpu.sv
// Directed bench for accum_cpu: an 8/8 core running small programs against a memory
// model with injectable write stalls, plus a 16/4 core checking pc wrap and reset during a stall.
module tb_accum_cpu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit data, 8-bit address core
  logic       rst = 1'b1, ready = 1'b1;
  logic [7:0] data_in, addr, data_out;
  logic       req, we, halted;
  logic [1:0] flags;
  logic [7:0] mem [256];

  // 16-bit data, 4-bit address core starting at F
  logic        rst2 = 1'b1, ready2 = 1'b1;
  logic [15:0] data_in2, data_out2;
  logic [3:0]  addr2;
  logic        req2, we2, halted2;
  logic [1:0]  flags2;
  logic [15:0] mem2 [16];

  accum_cpu #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .ready(ready), .req(req), .we(we),
    .addr(addr), .data_out(data_out), .halted(halted), .flags(flags)
  );

  accum_cpu #(.DATA_W(16), .ADDR_W(4), .RESET_PC(4'hF)) dut2 (
    .clk(clk), .rst(rst2), .data_in(data_in2), .ready(ready2), .req(req2), .we(we2),
    .addr(addr2), .data_out(data_out2), .halted(halted2), .flags(flags2)
  );

  assign data_in  = mem[addr];
  assign data_in2 = mem2[addr2];

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor for the 8-bit core: decides ready, commits writes, logs reads.
  int         stall_left = 0;
  int         we_cycles_80, writes_80, writes_all, bad_data_80;
  logic [7:0] read_log [$];

  initial forever begin
    @(negedge clk);
    if (req && we && stall_left > 0) begin
      ready = 1'b0;
      stall_left--;
    end else begin
      ready = 1'b1;
    end
    if (req && we && addr == 8'h80) begin
      we_cycles_80++;
      if (data_out !== 8'h42) bad_data_80++;
    end
    if (req && ready) begin
      if (we) begin
        mem[addr] = data_out;
        writes_all++;
        if (addr == 8'h80) writes_80++;
      end else begin
        read_log.push_back(addr);
      end
    end
    if (req2 && ready2 && we2) mem2[addr2] = data_out2;
  end

  logic first_req, first_we;
  logic [7:0] first_addr;

  // Hold reset, wipe memory and monitor state; program is loaded afterwards.
  task automatic reset_core();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    read_log.delete();
    we_cycles_80 = 0; writes_80 = 0; writes_all = 0; bad_data_80 = 0;
  endtask

  task automatic load(input logic [7:0] base, input logic [7:0] bytes [$]);
    for (int i = 0; i < bytes.size(); i++) mem[base + 8'(i)] = bytes[i];
  endtask

  // Release reset and count cycles until halted is visible (cycle 1 = first FETCH).
  task automatic run_prog(input string tag, output int cycles);
    @(posedge clk); #1 rst = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        first_req = req; first_we = we; first_addr = addr;
      end
    end while (!halted && cycles < 500);
    check({tag, "_halt"}, halted, 1'b1);
  endtask

  initial begin
    int cyc;

    // ---- reset values ----
    reset_core();
    load(8'h00, '{8'h07, 8'h05, 8'h06, 8'h07, 8'h03, 8'h10, 8'h02, 8'hF0, 8'h0F});
    @(negedge clk);
    check("rst_req", req, 1'b0);
    check("rst_addr", addr, 8'h00);
    check("rst_halted", halted, 1'b0);
    check("rst_flags", flags, 2'b00);

    // ---- basic program: 5 + 3 ----
    run_prog("p1", cyc);
    check("p1_first_req", first_req, 1'b1);
    check("p1_first_addr", first_addr, 8'h00);
    check("p1_first_we", first_we, 1'b0);
    check("p1_cycles", cyc, 17);
    check("p1_result", mem[8'hF0], 8'h08);
    check("p1_flags", flags, 2'b00);
    check("p1_halt_req", req, 1'b0);
    check("p1_halt_addr", addr, 8'h00);

    // ---- ADD overflow (Z and C via taken JZ/JC), then SUB borrow ----
    reset_core();
    load(8'h00, '{8'h07, 8'h01, 8'h06, 8'h07, 8'hFF, 8'h10, 8'h09, 8'h40, 8'h0F});
    load(8'h40, '{8'h0A, 8'h50, 8'h0F});
    load(8'h50, '{8'h02, 8'hF0, 8'h11, 8'h02, 8'hF1, 8'h0F});
    run_prog("p2", cyc);
    check("p2_add_a", mem[8'hF0], 8'h00);
    check("p2_sub_a", mem[8'hF1], 8'hFF);
    check("p2_flags", flags, 2'b10);

    // ---- STA/LDA, no wait states ----
    reset_core();
    load(8'h00, '{8'h07, 8'h42, 8'h02, 8'h80, 8'h07, 8'h00, 8'h01, 8'h80,
                  8'h02, 8'hF2, 8'h0F});
    run_prog("p3", cyc);
    check("p3_cycles", cyc, 21);
    check("p3_writes_80", writes_80, 1);
    check("p3_we_cycles", we_cycles_80, 1);
    check("p3_wdata", bad_data_80, 0);
    check("p3_mem80", mem[8'h80], 8'h42);
    check("p3_lda", mem[8'hF2], 8'h42);
    check("p3_flags", flags, 2'b00);

    // ---- same program, 3 wait states on the STA 80 MEM phase ----
    reset_core();
    load(8'h00, '{8'h07, 8'h42, 8'h02, 8'h80, 8'h07, 8'h00, 8'h01, 8'h80,
                  8'h02, 8'hF2, 8'h0F});
    stall_left = 3;
    run_prog("p3s", cyc);
    check("p3s_cycles", cyc, 24);
    check("p3s_writes_80", writes_80, 1);
    check("p3s_writes_all", writes_all, 2);
    check("p3s_we_cycles", we_cycles_80, 4);
    check("p3s_wdata", bad_data_80, 0);
    check("p3s_lda", mem[8'hF2], 8'h42);

    // ---- DIV by zero, taken JC, not-taken JZ, a<=pc, a<=b ----
    reset_core();
    load(8'h00, '{8'h07, 8'h00, 8'h06, 8'h07, 8'h10, 8'h13, 8'h0A, 8'h20, 8'h0F});
    load(8'h20, '{8'h02, 8'hF0, 8'h07, 8'h01, 8'h09, 8'h30, 8'h02, 8'hF3,
                  8'h03, 8'h06, 8'h07, 8'h00, 8'h05, 8'h02, 8'hF4, 8'h0F, 8'h0F});
    run_prog("p4", cyc);
    check("p4_div0_a", mem[8'hF0], 8'hFF);
    check("p4_jc_target", (read_log.size() > 8) ? read_log[8] : 8'hXX, 8'h20);
    check("p4_jz_fallthru", (read_log.size() > 14) ? read_log[14] : 8'hXX, 8'h26);
    check("p4_jz_not_taken", mem[8'hF3], 8'h01);
    check("p4_pc_to_a", mem[8'hF4], 8'h29);
    check("p4_flags", flags, 2'b10);

    // ---- 16/4 core: pc wrap from F, reset during an OPND stall ----
    for (int i = 0; i < 16; i++) mem2[i] = 16'h0000;
    mem2[4'hF] = 16'h0007;
    mem2[4'h0] = 16'h1234;
    mem2[4'h1] = 16'h0002;
    mem2[4'h2] = 16'h0005;
    mem2[4'h3] = 16'h000F;
    @(posedge clk); #1 rst2 = 1'b0;
    @(negedge clk);
    check("w_first_fetch", addr2, 4'hF);
    @(posedge clk); #1 ready2 = 1'b0;
    @(negedge clk);
    check("w_decode_req", req2, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("w_stall_req", req2, 1'b1);
      check("w_wrap_addr", addr2, 4'h0);
    end
    @(posedge clk); #1 rst2 = 1'b1;
    @(negedge clk);
    check("w_rst_req", req2, 1'b0);
    check("w_rst_addr", addr2, 4'h0);
    @(posedge clk); #1 rst2 = 1'b0; ready2 = 1'b1;
    @(negedge clk);
    check("w_restart_req", req2, 1'b1);
    check("w_restart_pc", addr2, 4'hF);
    cyc = 0;
    while (!halted2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("w_halt", halted2, 1'b1);
    check("w_sta16", mem2[4'h5], 16'h1234);
    check("w_flags", flags2, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
